score_bcd_counter: RTL and testbench
====================================

Name: score_bcd_counter

Overview:
Game score accumulator that sits directly upstream of the 7-segment decode stage. It takes point-award pulses from collision logic, adds them to the running score one point per clock, and saturates at 999. It exposes the score as a 10-bit binary value and as three BCD digits, one 4-bit nibble per display decoder. It also keeps a session high score, updated on game-over.

Parameters:
PEND_W, 6, width of the pending-points accumulator; pending saturates at 2^PEND_W-1 (63).
MAX_SCORE, 999, saturation value of the score; must be ≤ 999 and fit 10 bits.

Ports:
clk  input  1  system clock, rising-edge.
resetn  input  1  asynchronous active-low reset.
clear  input  1  synchronous game-start clear of the score (high score retained).
hit_valid  input  1  one-cycle award strobe.
hit_points  input  4  points awarded with hit_valid; 0..15, value 0 is ignored.
game_over  input  1  one-cycle end-of-game strobe.
score  output  10  current committed score, binary.
digit0  output  4  BCD ones digit of score.
digit1  output  4  BCD tens digit.
digit2  output  4  BCD hundreds digit.
hi_score  output  10  session high score, binary.
busy  output  1  high while pending points are being applied.
saturated  output  1  sticky; score reached MAX_SCORE.
new_high  output  1  one-cycle pulse when hi_score is replaced.

Behaviour:
- Reset (resetn low, asynchronous): all outputs 0; pending=0; state IDLE; game-over flag 0.
- Encoding invariant: score == 100*digit2 + 10*digit1 + digit0 at every clock edge. Digits are always 0..9.
- FSM states: IDLE and COUNT. busy = (state==COUNT).
- IDLE, on hit_valid with hit_points>0 and not saturated:
  - pending <= hit_points; go to COUNT.
  - score is unchanged this edge.
- COUNT, every edge:
  - score +1 (binary) and BCD +1 with ripple: digit0 9→0 carries to digit1; digit1 9→0 carries to digit2.
  - pending <= pending - 1 + (hit_valid ? hit_points : 0), saturating at 2^PEND_W-1.
  - Go to IDLE when the next pending is 0.
- Latency: a hit of k points sampled at edge N gives score S+k after edge N+k. busy is high for edges N+1..N+k.
- Saturation:
  - When an increment would make score equal MAX_SCORE, score becomes MAX_SCORE, saturated <= 1, pending <= 0, state -> IDLE.
  - While saturated, hits are discarded.
- clear has priority over everything except reset:
  - score and digits <= 0; pending <= 0; saturated <= 0; state -> IDLE; game-over flag cleared.
  - A hit arriving in the same cycle as clear is dropped.
  - hi_score is unchanged.
- game_over:
  - Sets an internal flag, so a strobe during COUNT is deferred.
  - At the first edge where the state is IDLE, the flag is set and no clear is asserted:
    - if score > hi_score: hi_score <= score and new_high = 1 for exactly one cycle;
    - in all cases, clear the flag.
  - If the state is already IDLE when game_over arrives, the compare happens at the following edge.
  - A hit arriving in the same cycle as the flag-processing edge still starts COUNT; the compare uses the pre-hit score.
- A repeated game_over while the flag is already set has no extra effect.
- Reset asserted mid-COUNT abandons pending points immediately; hi_score is also reset to 0.

Test Plan:
1. After reset, hit_valid with hit_points=5 at edge 0 → busy high for edges 1..5; score=5, digits 0/0/5 after edge 5; busy=0 after edge 5.
2. Score 9, hit_points=1 → score=10, digit0=0, digit1=1, digit2=0. Score 99, hit 1 → 100, digits 0/0/1.
3. Overlapping hits: hit 3 at edge 0, hit 4 at edge 2 → score=7 after edge 7; busy continuous over edges 1..7.
4. Saturation: score 995, hit 9 → score=999 after edge 4, saturated=1, busy=0; a further hit of 2 leaves score at 999.
5. game_over at edge 2 during a 5-point count from 0 with hi_score=3 → after COUNT ends, hi_score=5 and new_high pulses for one cycle. A second game with final score 4 → hi_score stays 5, no pulse.
6. clear at edge 3 of a 9-point count → score=0, busy=0, hi_score unchanged. resetn low mid-count → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/score_bcd_counter.sv
// Game score accumulator: applies awarded points one per clock, keeps binary and BCD views
// of the score, saturates at MAX_SCORE and tracks the session high score on game-over.
module score_bcd_counter #(
  parameter int unsigned PEND_W    = 6,
  parameter int unsigned MAX_SCORE = 999
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       hit_valid,
  input  logic [3:0] hit_points,
  input  logic       game_over,
  output logic [9:0] score,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [9:0] hi_score,
  output logic       busy,
  output logic       saturated,
  output logic       new_high
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  localparam int unsigned SUM_W = PEND_W + 5;
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [9:0]        SCORE_MAX = 10'(MAX_SCORE);
  localparam logic [9:0]        SCORE_PRE = 10'(MAX_SCORE - 1);
  localparam logic [3:0]        MAX_D0    = 4'(MAX_SCORE % 10);
  localparam logic [3:0]        MAX_D1    = 4'((MAX_SCORE / 10) % 10);
  localparam logic [3:0]        MAX_D2    = 4'(MAX_SCORE / 100);

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [9:0]        score_q, score_d;
  logic [3:0]        d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [9:0]        hi_q, hi_d;
  logic              sat_q, sat_d;
  logic              flag_q, flag_d;
  logic              new_high_q, new_high_d;

  logic              start;
  logic              hit_max;
  logic              proc;
  logic [3:0]        hit_add;
  logic [SUM_W-1:0]  pend_sum;
  logic [PEND_W-1:0] pend_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      score_q    <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      hi_q       <= '0;
      sat_q      <= 1'b0;
      flag_q     <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      score_q    <= score_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      hi_q       <= hi_d;
      sat_q      <= sat_d;
      flag_q     <= flag_d;
      new_high_q <= new_high_d;
    end
  end

  always_comb begin
    start    = hit_valid && (hit_points != 4'd0) && !sat_q;
    hit_max  = (score_q == SCORE_PRE);
    hit_add  = hit_valid ? hit_points : 4'd0;
    // Only meaningful in StCount, where pend_q is at least 1.
    pend_sum = SUM_W'(pend_q) + SUM_W'(hit_add) - SUM_W'(1);
    pend_nxt = (pend_sum > SUM_W'(PEND_MAX)) ? PEND_MAX : pend_sum[PEND_W-1:0];
    proc     = flag_q && (state_q == StIdle);

    state_d    = state_q;
    pend_d     = pend_q;
    score_d    = score_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    hi_d       = hi_q;
    sat_d      = sat_q;
    flag_d     = flag_q;
    new_high_d = 1'b0;

    if (clear) begin
      state_d = StIdle;
      pend_d  = '0;
      score_d = '0;
      d0_d    = '0;
      d1_d    = '0;
      d2_d    = '0;
      sat_d   = 1'b0;
      flag_d  = 1'b0;
    end else begin
      // Compare uses the pre-increment score even if a hit starts counting this edge.
      new_high_d = proc && (score_q > hi_q);
      if (new_high_d) hi_d = score_q;
      flag_d = proc ? 1'b0 : (flag_q | game_over);

      unique case (state_q)
        StIdle: begin
          if (start) begin
            pend_d  = PEND_W'(hit_points);
            state_d = StCount;
          end
        end
        StCount: begin
          if (hit_max) begin
            score_d = SCORE_MAX;
            d0_d    = MAX_D0;
            d1_d    = MAX_D1;
            d2_d    = MAX_D2;
            sat_d   = 1'b1;
            pend_d  = '0;
            state_d = StIdle;
          end else begin
            score_d = score_q + 10'd1;
            if (d0_q == 4'd9) begin
              d0_d = 4'd0;
              if (d1_q == 4'd9) begin
                d1_d = 4'd0;
                d2_d = d2_q + 4'd1;
              end else begin
                d1_d = d1_q + 4'd1;
              end
            end else begin
              d0_d = d0_q + 4'd1;
            end
            pend_d = pend_nxt;
            if (pend_nxt == '0) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == StCount);
    score     = score_q;
    digit0    = d0_q;
    digit1    = d1_q;
    digit2    = d2_q;
    hi_score  = hi_q;
    saturated = sat_q;
    new_high  = new_high_q;
  end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: a directed vector table, hand-written corner sequences and
// random traffic, all compared each cycle against an arithmetic model of the score rules.
module tb_score_bcd_counter;

  localparam int MAX = 999;
  localparam int PMAX = 63;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic       hit_valid = 1'b0;
  logic [3:0] hit_points = 4'd0;
  logic       game_over = 1'b0;
  logic [9:0] score, hi_score;
  logic [3:0] digit0, digit1, digit2;
  logic       busy, saturated, new_high;

  int n_checks = 0;
  int n_fail = 0;
  int nh_seen = 0;

  // Model state: COUNT is simply "points still pending".
  int m_score, m_pend, m_hi;
  bit m_sat, m_flag, m_nh;

  typedef struct {
    bit hv;
    int hp;
    int exp_score;
    bit exp_busy;
  } vec_t;
  vec_t tbl[14];

  score_bcd_counter #(.PEND_W(6), .MAX_SCORE(MAX)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .hit_valid(hit_valid),
    .hit_points(hit_points), .game_over(game_over), .score(score), .digit0(digit0),
    .digit1(digit1), .digit2(digit2), .hi_score(hi_score), .busy(busy),
    .saturated(saturated), .new_high(new_high)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_pend = 0; m_hi = 0; m_sat = 0; m_flag = 0; m_nh = 0;
  endtask

  task automatic model_step(input bit c, input bit hv, input int hp, input bit go);
    bit proc;
    if (c) begin
      m_score = 0; m_pend = 0; m_sat = 0; m_flag = 0; m_nh = 0;
      return;
    end
    proc = m_flag && (m_pend == 0);
    m_nh = proc && (m_score > m_hi);
    if (m_nh) m_hi = m_score;
    m_flag = proc ? 1'b0 : (m_flag | go);
    if (m_pend == 0) begin
      if (hv && hp > 0 && !m_sat) m_pend = hp;
    end else begin
      m_score++;
      if (m_score == MAX) begin
        m_sat = 1;
        m_pend = 0;
      end else begin
        m_pend = m_pend - 1 + (hv ? hp : 0);
        if (m_pend > PMAX) m_pend = PMAX;
      end
    end
  endtask

  task automatic check_model();
    check("score", score, m_score);
    check("digit0", digit0, m_score % 10);
    check("digit1", digit1, (m_score / 10) % 10);
    check("digit2", digit2, m_score / 100);
    check("hi_score", hi_score, m_hi);
    check("busy", busy, int'(m_pend > 0));
    check("saturated", saturated, m_sat);
    check("new_high", new_high, m_nh);
  endtask

  task automatic cycle(input bit c, input bit hv, input int hp, input bit go);
    clear = c; hit_valid = hv; hit_points = 4'(hp); game_over = go;
    @(posedge clk);
    model_step(c, hv, hp, go);
    #1;
    check_model();
    if (new_high) nh_seen++;
    clear = 1'b0; hit_valid = 1'b0; hit_points = 4'd0; game_over = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0);
  endtask

  task automatic award(input int p);
    int k;
    k = 0;
    cycle(0, 1, p, 0);
    while (busy && k < 100) begin
      cycle(0, 0, 0, 0);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL award_timeout: busy still 1 expected 0 at %0t", $time);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5, 0, 1'b1};
    tbl[1]  = '{1'b0, 0, 1, 1'b1};
    tbl[2]  = '{1'b0, 0, 2, 1'b1};
    tbl[3]  = '{1'b0, 0, 3, 1'b1};
    tbl[4]  = '{1'b0, 0, 4, 1'b1};
    tbl[5]  = '{1'b0, 0, 5, 1'b0};
    tbl[6]  = '{1'b1, 3, 5, 1'b1};
    tbl[7]  = '{1'b0, 0, 6, 1'b1};
    tbl[8]  = '{1'b1, 4, 7, 1'b1};
    tbl[9]  = '{1'b0, 0, 8, 1'b1};
    tbl[10] = '{1'b0, 0, 9, 1'b1};
    tbl[11] = '{1'b0, 0, 10, 1'b1};
    tbl[12] = '{1'b0, 0, 11, 1'b1};
    tbl[13] = '{1'b0, 0, 12, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    resetn = 1'b1;

    // Single 5-point hit, then overlapping 3 + 4 hits.
    for (int i = 0; i < 14; i++) begin
      cycle(0, tbl[i].hv, tbl[i].hp, 0);
      check("tbl_score", score, tbl[i].exp_score);
      check("tbl_busy", busy, tbl[i].exp_busy);
      check("tbl_bcd", digit2 * 100 + digit1 * 10 + digit0, tbl[i].exp_score);
    end

    // BCD carries: 9 -> 10 and 99 -> 100.
    cycle(1, 0, 0, 0);
    award(9);
    check("s9", score, 9);
    award(1);
    check("s10", score, 10);
    check("s10_d0", digit0, 0);
    check("s10_d1", digit1, 1);
    check("s10_d2", digit2, 0);
    repeat (5) award(15);
    award(14);
    check("s99", score, 99);
    award(1);
    check("s100", score, 100);
    check("s100_d0", digit0, 0);
    check("s100_d1", digit1, 0);
    check("s100_d2", digit2, 1);

    // Saturation at 999 and discard afterwards.
    repeat (59) award(15);
    award(10);
    check("s995", score, 995);
    cycle(0, 1, 9, 0);
    idle(4);
    check("sat_score", score, 999);
    check("sat_flag", saturated, 1);
    check("sat_busy", busy, 0);
    cycle(0, 1, 2, 0);
    idle(3);
    check("sat_hold", score, 999);
    check("sat_hold_busy", busy, 0);

    // High score: first game to 3, then deferred game_over during a 5-point count.
    cycle(1, 0, 0, 0);
    award(3);
    nh_seen = 0;
    cycle(0, 0, 0, 1);
    idle(2);
    check("hi3", hi_score, 3);
    check("hi3_pulses", nh_seen, 1);
    cycle(1, 0, 0, 0);
    nh_seen = 0;
    cycle(0, 1, 5, 0);
    idle(1);
    cycle(0, 0, 0, 1);
    idle(6);
    check("hi5", hi_score, 5);
    check("hi5_pulses", nh_seen, 1);
    cycle(1, 0, 0, 0);
    nh_seen = 0;
    award(4);
    cycle(0, 0, 0, 1);
    idle(3);
    check("hi_keep", hi_score, 5);
    check("hi_keep_pulses", nh_seen, 0);

    // Clear mid-count, then asynchronous reset mid-count.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 9, 0);
    idle(2);
    cycle(1, 0, 0, 0);
    check("clr_score", score, 0);
    check("clr_busy", busy, 0);
    check("clr_hi", hi_score, 5);
    cycle(0, 1, 9, 0);
    idle(3);
    resetn = 1'b0;
    #2;
    model_reset();
    check("rst_score", score, 0);
    check("rst_busy", busy, 0);
    check("rst_hi", hi_score, 0);
    check_model();
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Random traffic: frequent clears first, then rare clears so saturation is reached.
    for (int i = 0; i < 4000; i++) begin
      bit c, hv, go;
      c  = (i < 2000) ? ($urandom_range(63) == 0) : ($urandom_range(1999) == 0);
      hv = ($urandom_range(9) < 3);
      go = ($urandom_range(31) == 0);
      cycle(c, hv, int'($urandom_range(15)), go);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
